// File: rtl/ppu_pkg.sv
// ppu_pkg: shared widths, field offsets and loader FSM states for the PPU feeder
package ppu_pkg;
    localparam int SPR_W      = 30;
    localparam int STAT_W     = 22;
    localparam int N_SPR      = 6;
    localparam int N_STAT     = 6;
    localparam int SPR_TBL_W  = SPR_W * N_SPR;
    localparam int STAT_TBL_W = STAT_W * N_STAT;
    localparam int SPR_X      = 0;
    localparam int SPR_Y      = 11;
    localparam int SPR_CHAR   = 22;
    localparam int SPR_ATTR   = 28;
    localparam int STAT_COL   = 0;
    localparam int STAT_ROW   = 7;
    localparam int STAT_CHAR  = 14;
    localparam int STAT_ATTR  = 20;
    typedef enum logic [1:0] {IDLE, ARMED, PUBLISH, STROBE} state_t;
endpackage

// File: rtl/camera_axis.sv
// camera_axis: one axis of the viewport follower, clamps the centred target and limits the step
//   cur_i    in  12  currently published offset
//   target_i in  12  player world coordinate
//   next_o   out 12  offset to publish next frame
module camera_axis #(
    parameter int HALF     = 640,
    parameter int MAX_OFF  = 768,
    parameter int MAX_STEP = 8
) (
    input  logic [11:0] cur_i,
    input  logic [11:0] target_i,
    output logic [11:0] next_o
);
    logic signed [12:0] raw, des, d;
    assign raw = $signed({1'b0, target_i}) - signed'(13'(HALF));
    assign des = raw < 0 ? 13'sd0 : (raw > signed'(13'(MAX_OFF)) ? signed'(13'(MAX_OFF)) : raw);
    assign d   = des - $signed({1'b0, cur_i});
    // within one step of the goal we land on it exactly, so the offset never overshoots the clamp
    assign next_o = d > signed'(13'(MAX_STEP))  ? cur_i + 12'(MAX_STEP) :
                    d < -signed'(13'(MAX_STEP)) ? cur_i - 12'(MAX_STEP) : des[11:0];
endmodule

// File: rtl/frame_table_loader.sv
// frame_table_loader: shadows sprite/static tables and publishes them with scroll once per vsync
//   clock, reset   clock and asynchronous active-high reset
//   vsync          vertical sync, active level VSYNC_POL
//   wr_*           table write handshake (kind 0 sprite, 1 static; index 0..5)
//   commit         request to publish at the next vsync
//   target_x/_y    player world position the viewport follows
//   sprites/statics/offset_x/offset_y  published state, changes only when publishing
//   update         one-cycle strobe after publishing; pending high while a commit waits
module frame_table_loader
    import ppu_pkg::*;
#(
    parameter int HALF_W    = 640,
    parameter int HALF_H    = 512,
    parameter int MAX_OFF_X = 768,
    parameter int MAX_OFF_Y = 1024,
    parameter int MAX_STEP  = 8,
    parameter bit VSYNC_POL = 1'b0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  vsync,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic                  wr_kind,
    input  logic [2:0]            wr_index,
    input  logic [SPR_W-1:0]      wr_data,
    input  logic                  commit,
    input  logic [11:0]           target_x,
    input  logic [11:0]           target_y,
    output logic [SPR_TBL_W-1:0]  sprites,
    output logic [STAT_TBL_W-1:0] statics,
    output logic [11:0]           offset_x,
    output logic [11:0]           offset_y,
    output logic                  update,
    output logic                  pending
);
    state_t                  state_q, state_d;
    logic                    vs_q, vs_q_d, vs_edge, wr_fire;
    logic [SPR_TBL_W-1:0]    spr_sh_q, sprites_q;
    logic [STAT_TBL_W-1:0]   stat_sh_q, statics_q;
    logic [11:0]             offx_q, offy_q, offx_d, offy_d;

    assign vs_edge  = vs_q & ~vs_q_d;
    assign wr_ready = state_q == IDLE;
    assign wr_fire  = wr_valid & wr_ready;
    assign update   = state_q == STROBE;
    assign pending  = state_q == ARMED || state_q == PUBLISH;
    assign sprites  = sprites_q;
    assign statics  = statics_q;
    assign offset_x = offx_q;
    assign offset_y = offy_q;

    camera_axis #(.HALF(HALF_W), .MAX_OFF(MAX_OFF_X), .MAX_STEP(MAX_STEP)) u_cam_x (
        .cur_i(offx_q), .target_i(target_x), .next_o(offx_d)
    );
    camera_axis #(.HALF(HALF_H), .MAX_OFF(MAX_OFF_Y), .MAX_STEP(MAX_STEP)) u_cam_y (
        .cur_i(offy_q), .target_i(target_y), .next_o(offy_d)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = commit ? ARMED : IDLE;
            ARMED:   state_d = vs_edge ? PUBLISH : ARMED;
            PUBLISH: state_d = STROBE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            vs_q    <= 1'b0;
            vs_q_d  <= 1'b0;
        end else begin
            state_q <= state_d;
            vs_q    <= vsync == VSYNC_POL;
            vs_q_d  <= vs_q;
        end
    end

    // out-of-range indices match no entry, so such writes complete and are dropped
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            spr_sh_q  <= '0;
            stat_sh_q <= '0;
        end else if (wr_fire) begin
            for (int i = 0; i < N_SPR; i++)
                if (!wr_kind && wr_index == 3'(i)) spr_sh_q[i*SPR_W +: SPR_W] <= wr_data;
            for (int i = 0; i < N_STAT; i++)
                if (wr_kind && wr_index == 3'(i)) stat_sh_q[i*STAT_W +: STAT_W] <= wr_data[STAT_W-1:0];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sprites_q <= '0;
            statics_q <= '0;
            offx_q    <= '0;
            offy_q    <= '0;
        end else if (state_q == PUBLISH) begin
            sprites_q <= spr_sh_q;
            statics_q <= stat_sh_q;
            offx_q    <= offx_d;
            offy_q    <= offy_d;
        end
    end
endmodule

// File: tb/tb_frame_table_loader.sv
// tb_frame_table_loader: directed checks of table shadowing, vsync publishing and camera stepping
module tb_frame_table_loader;
    logic         clock = 0, reset = 1, vsync = 1, wr_valid = 0, wr_kind = 0, commit = 0;
    logic [2:0]   wr_index = 0;
    logic [29:0]  wr_data = 0;
    logic [11:0]  target_x = 0, target_y = 0;
    logic         wr_ready, update, pending;
    logic [179:0] sprites, exp_spr;
    logic [131:0] statics, exp_stat;
    logic [11:0]  offset_x, offset_y;
    int           total = 0, bad = 0;

    frame_table_loader dut (
        .clock(clock), .reset(reset), .vsync(vsync), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_kind(wr_kind), .wr_index(wr_index), .wr_data(wr_data), .commit(commit),
        .target_x(target_x), .target_y(target_y), .sprites(sprites), .statics(statics),
        .offset_x(offset_x), .offset_y(offset_y), .update(update), .pending(pending)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [179:0] obs, input logic [179:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic kind, input logic [2:0] idx, input logic [29:0] data);
        wr_valid = 1; wr_kind = kind; wr_index = idx; wr_data = data;
        chk("wr_ready_idle", 180'(wr_ready), 180'(1));
        tick();
        wr_valid = 0;
    endtask

    task automatic vs_idle();
        vsync = 0;
        tick();
        vsync = 1;
        chk("idle_edge_update", 180'(update), 180'(0));
        tick();
        chk("idle_edge_update1", 180'(update), 180'(0));
        tick();
        chk("idle_edge_update2", 180'(update), 180'(0));
    endtask

    task automatic arm();
        commit = 1;
        tick();
        commit = 0;
        chk("armed_pending", 180'(pending), 180'(1));
        chk("armed_ready", 180'(wr_ready), 180'(0));
    endtask

    task automatic publish(input logic commit_in_strobe);
        vsync = 0;
        tick();
        vsync = 1;
        chk("edge_cycle_update", 180'(update), 180'(0));
        tick();
        chk("publish_cycle_update", 180'(update), 180'(0));
        tick();
        chk("strobe_update", 180'(update), 180'(1));
        commit = commit_in_strobe;
        tick();
        commit = 0;
        chk("after_strobe_update", 180'(update), 180'(0));
        chk("after_strobe_pending", 180'(pending), 180'(0));
        chk("after_strobe_ready", 180'(wr_ready), 180'(1));
    endtask

    task automatic chk_offs(input string tag, input logic [11:0] ex, input logic [11:0] ey);
        chk({tag, "_x"}, 180'(offset_x), 180'(ex));
        chk({tag, "_y"}, 180'(offset_y), 180'(ey));
    endtask

    initial begin
        tick();
        chk("reset_ready", 180'(wr_ready), 180'(1));
        chk("reset_update", 180'(update), 180'(0));
        chk("reset_pending", 180'(pending), 180'(0));
        tick();
        reset = 0;
        tick();
        // 1: vsync edges without commit do nothing
        repeat (3) vs_idle();
        chk("t1_sprites", sprites, '0);
        chk("t1_statics", 180'(statics), '0);
        chk_offs("t1_off", 12'd0, 12'd0);
        // 2: basic publish; static bits above 21 are dropped
        wr(1'b0, 3'd2, 30'h0ABCDEF1);
        wr(1'b1, 3'd5, 30'h3FFFFFFF);
        chk("t2_not_yet", sprites, '0);
        arm();
        publish(1'b0);
        exp_spr = '0;
        exp_spr[89:60] = 30'h0ABCDEF1;
        exp_stat = '0;
        exp_stat[131:110] = 22'h3FFFFF;
        chk("t2_sprites", sprites, exp_spr);
        chk("t2_statics", 180'(statics), 180'(exp_stat));
        chk_offs("t2_off", 12'd0, 12'd0);
        // 3: camera follows toward the clamp, then back down to zero
        target_x = 12'd2000; target_y = 12'd2000;
        for (int k = 1; k <= 129; k++) begin
            arm();
            publish(1'b0);
            if (k == 1) chk_offs("t3_f1", 12'd8, 12'd8);
            if (k == 2) chk_offs("t3_f2", 12'd16, 12'd16);
            if (k == 96) chk_offs("t3_f96", 12'd768, 12'd768);
            if (k == 128) chk_offs("t3_f128", 12'd768, 12'd1024);
            if (k == 129) chk_offs("t3_hold", 12'd768, 12'd1024);
        end
        target_x = 12'd100; target_y = 12'd100;
        for (int k = 1; k <= 129; k++) begin
            arm();
            publish(1'b0);
            if (k == 1) chk_offs("t3_down1", 12'd760, 12'd1016);
            if (k == 96) chk_offs("t3_down96", 12'd0, 12'd256);
            if (k == 129) chk_offs("t3_down_hold", 12'd0, 12'd0);
        end
        target_x = 12'd645; target_y = 12'd515;
        arm();
        publish(1'b0);
        chk_offs("t3_small", 12'd5, 12'd3);
        target_x = 12'd0; target_y = 12'd0;
        arm();
        publish(1'b0);
        chk_offs("t3_back0", 12'd0, 12'd0);
        // 4: writes while armed are refused
        arm();
        wr_valid = 1; wr_kind = 0; wr_index = 3'd2; wr_data = 30'h1234;
        chk("t4_ready_armed", 180'(wr_ready), 180'(0));
        tick();
        wr_valid = 0;
        publish(1'b0);
        chk("t4_sprites", sprites, exp_spr);
        arm();
        publish(1'b0);
        chk("t4_shadow_kept", sprites, exp_spr);
        // commit during strobe is ignored
        arm();
        publish(1'b1);
        chk("strobe_commit_pending", 180'(pending), 180'(0));
        vs_idle();
        // 5: out-of-range index writes are discarded
        wr(1'b0, 3'd6, 30'h1);
        wr(1'b1, 3'd7, 30'h1);
        arm();
        publish(1'b0);
        chk("t5_sprites", sprites, exp_spr);
        chk("t5_statics", 180'(statics), 180'(exp_stat));
        // write in the same cycle as commit is accepted
        wr_valid = 1; wr_kind = 0; wr_index = 3'd0; wr_data = 30'h2A; commit = 1;
        tick();
        wr_valid = 0; commit = 0;
        chk("t5_same_pending", 180'(pending), 180'(1));
        publish(1'b0);
        exp_spr[29:0] = 30'h2A;
        chk("t5_same_sprites", sprites, exp_spr);
        // 6: reset while publishing
        arm();
        vsync = 0;
        tick();
        vsync = 1;
        tick();
        reset = 1;
        #1;
        chk("t6_sprites", sprites, '0);
        chk("t6_statics", 180'(statics), '0);
        chk("t6_update", 180'(update), 180'(0));
        chk("t6_pending", 180'(pending), 180'(0));
        tick();
        reset = 0;
        tick();
        chk("t6_ready", 180'(wr_ready), 180'(1));
        chk("t6_update_after", 180'(update), 180'(0));
        tick();
        chk("t6_update_later", 180'(update), 180'(0));
        arm();
        publish(1'b0);
        chk("t6_shadow_cleared", sprites, '0);
        chk("t6_stat_cleared", 180'(statics), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
